// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction field layout and the forced hold/default instruction words.
// No logic; imported by ifetch_seq and its program store.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } fetch_state_e;

    localparam int INS_TYPE_W = 2;
    localparam int INS_IR_W   = 1;
    localparam int INS_OPC_W  = 4;
    localparam int INS_TGT_W  = 3;
    localparam int INS_AMUX_W = 3;
    localparam int INS_BMUX_W = 8;
    localparam int INS_W_DEF  = INS_TYPE_W + INS_IR_W + INS_OPC_W
                              + INS_TGT_W + INS_AMUX_W + INS_BMUX_W;

    // Field order from MSB down; bmux doubles as the 8-bit immediate.
    typedef struct packed {
        logic [INS_TYPE_W-1:0] ins_type;
        logic [INS_IR_W-1:0]   ir;
        logic [INS_OPC_W-1:0]  opcode;
        logic [INS_TGT_W-1:0]  tgt;
        logic [INS_AMUX_W-1:0] amux;
        logic [INS_BMUX_W-1:0] bmux;
    } ins_t;

    // Type 00, opcode 0111, imm 0xFF: keeps the CPU parked while the store is rewritten.
    localparam logic [INS_W_DEF-1:0] HOLD_INS_DEF    = 21'h01C0FF;
    localparam logic [INS_W_DEF-1:0] DEFAULT_INS_DEF = 21'h090114;

    function automatic logic is_fetch_state(input fetch_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: DEPTH x DATA_W, one synchronous write port, one async read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none; caller gates wr_vld.
module prog_ram #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              core_clk,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Deliberately no reset: contents survive a reset and are hidden by PROG_LEN.
    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: run-time loadable program store plus run/halt/step CPU clock-enable.
// Latency: INS is combinational from ADDR; state, PROG_LEN and FETCH_OOB update on the next CLK edge.
// Backpressure: LOAD_READY is high only in LOAD; words are taken on LOAD_VALID & LOAD_READY.
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int                 INS_W       = 21,
    parameter int                 ADDR_W      = 8,
    parameter int                 DEPTH       = 256,
    parameter logic [INS_W-1:0]   HOLD_INS    = INS_W'(HOLD_INS_DEF),
    parameter logic [INS_W-1:0]   DEFAULT_INS = INS_W'(DEFAULT_INS_DEF)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [INS_W-1:0]  INS,
    output logic              CPU_CE,
    input  logic              RUN_EN,
    input  logic              STEP_REQ,
    input  logic              LOAD_START,
    input  logic              LOAD_VALID,
    input  logic [INS_W-1:0]  LOAD_DATA,
    input  logic              LOAD_LAST,
    output logic              LOAD_READY,
    output logic [1:0]        STATE,
    output logic [ADDR_W:0]   PROG_LEN,
    output logic              FETCH_OOB
);

    localparam int              RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RAM_AW-1:0] WPTR_MAX = RAM_AW'(DEPTH - 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W:0]   prog_len_q;
    logic [RAM_AW-1:0] wptr_q;
    logic              oob_q;

    logic              load_fire;
    logic              load_end;
    logic              load_entry;
    logic              addr_hit;
    logic [INS_W-1:0]  ram_rd_dat;

    assign load_fire  = (state_q == ST_LOAD) && LOAD_VALID;
    // Full store ends the load exactly like LOAD_LAST, so no write can pass DEPTH-1.
    assign load_end   = load_fire && (LOAD_LAST || (wptr_q == WPTR_MAX));
    assign load_entry = (state_q != ST_LOAD) && (state_d == ST_LOAD);
    assign addr_hit   = {1'b0, ADDR} < prog_len_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (LOAD_START)    state_d = ST_LOAD;
                else if (RUN_EN)   state_d = ST_RUN;
                else if (STEP_REQ) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (LOAD_START)    state_d = ST_LOAD;
                else if (!RUN_EN)  state_d = ST_HALT;
            end
            ST_STEP: begin
                state_d = LOAD_START ? ST_LOAD : ST_HALT;
            end
            ST_LOAD: begin
                if (load_end)      state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_HALT;
            prog_len_q <= '0;
            wptr_q     <= '0;
            oob_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_entry) begin
                prog_len_q <= '0;
                wptr_q     <= '0;
                oob_q      <= 1'b0;
            end else begin
                if (load_fire) begin
                    wptr_q     <= wptr_q + RAM_AW'(1);
                    prog_len_q <= (ADDR_W + 1)'(wptr_q) + (ADDR_W + 1)'(1);
                end
                if (is_fetch_state(state_q) && !addr_hit) begin
                    oob_q <= 1'b1;
                end
            end
        end
    end

    prog_ram #(
        .DATA_W (INS_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_prog_ram (
        .core_clk (CLK),
        .wr_vld   (load_fire),
        .wr_addr  (wptr_q),
        .wr_dat   (LOAD_DATA),
        .rd_addr  (ADDR[RAM_AW-1:0]),
        .rd_dat   (ram_rd_dat)
    );

    always_comb begin
        INS = DEFAULT_INS;
        if (state_q == ST_LOAD) INS = HOLD_INS;
        else if (addr_hit)      INS = ram_rd_dat;
    end

    assign CPU_CE     = (state_q != ST_HALT);
    assign LOAD_READY = (state_q == ST_LOAD);
    assign STATE      = state_q;
    assign PROG_LEN   = prog_len_q;
    assign FETCH_OOB  = oob_q;

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Parametrised successor to the fixed program ROM and reset-instruction mux in front of the 8-bit CPU.
- Holds a writable program store that is loaded at run time over a valid/ready port, and serves instructions combinationally from the CPU address.
- Adds run/halt/single-step control via a CPU clock-enable.
- Forces a hold instruction while loading, and a default instruction for fetches beyond the loaded program.

Parameters:
- INS_W, 21, instruction width.
- ADDR_W, 8, CPU address width.
- DEPTH, 256, program words; must be <= 2**ADDR_W.
- HOLD_INS, 21'h01C0FF, instruction forced during LOAD (type 00, opcode 0111, imm 0xFF).
- DEFAULT_INS, 21'h090114, instruction returned for addresses >= PROG_LEN.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDR  in  ADDR_W  CPU program address.
- INS  out  INS_W  instruction to CPU; combinational from ADDR and state.
- CPU_CE  out  1  CPU clock enable.
- RUN_EN  in  1  level; run while high.
- STEP_REQ  in  1  synchronous single-cycle pulse; execute one instruction.
- LOAD_START  in  1  pulse; begin program load.
- LOAD_VALID  in  1  load word valid.
- LOAD_DATA  in  INS_W  load word.
- LOAD_LAST  in  1  marks final word; qualified by LOAD_VALID.
- LOAD_READY  out  1  high only in LOAD.
- STATE  out  2  00 HALT, 01 RUN, 10 STEP, 11 LOAD.
- PROG_LEN  out  ADDR_W+1  number of valid words loaded.
- FETCH_OOB  out  1  sticky: a fetch was enabled with ADDR >= PROG_LEN.

Behaviour:
Reset (RESET_N low, asynchronous):
- STATE=HALT, PROG_LEN=0, write pointer=0, FETCH_OOB=0.
- CPU_CE=0, LOAD_READY=0.
- RAM contents are not reset. With PROG_LEN=0, every fetch returns DEFAULT_INS.

INS mux:
- LOAD: HOLD_INS.
- Otherwise: mem[ADDR] if ADDR < PROG_LEN, else DEFAULT_INS.
- Zero-latency path from ADDR.

CPU_CE:
- 1 in RUN, 1 in STEP, 1 in LOAD (CPU clocked on HOLD_INS, matching the old reset behaviour).
- 0 in HALT.

FSM:
- Transition priority everywhere: LOAD_START > RUN_EN > STEP_REQ.
- HALT: LOAD_START -> LOAD; else RUN_EN -> RUN; else STEP_REQ -> STEP; else stay.
- RUN: LOAD_START -> LOAD; else !RUN_EN -> HALT.
- STEP: lasts exactly 1 cycle, so exactly one CE cycle. Next state is LOAD if LOAD_START, else HALT. RUN_EN is ignored in STEP.
- STEP_REQ in RUN or LOAD is ignored.
- Entering LOAD: PROG_LEN<=0, write pointer<=0, FETCH_OOB<=0.
- LOAD: LOAD_READY=1. On LOAD_VALID & LOAD_READY:
  - mem[wptr]<=LOAD_DATA, wptr<=wptr+1, PROG_LEN<=wptr+1.
  - If LOAD_LAST, or wptr==DEPTH-1: next state HALT. The last word is written in the same cycle.
- LOAD_START and RUN_EN are ignored while in LOAD; exit is only through LAST/full.
- No write can land beyond DEPTH-1.

FETCH_OOB:
- Set on any cycle with STATE in {RUN, STEP} and ADDR >= PROG_LEN.
- Held until the next LOAD entry or reset.

Reset mid-load:
- Aborts the load; PROG_LEN=0.
- Already-written words remain in RAM but are unreachable.

Decomposition:
- Package ifetch_pkg:
  - state encoding constants (HALT/RUN/STEP/LOAD).
  - instruction field widths (type 2, I/R 1, opcode 4, tgt 3, amux 3, bmux/imm 8).
  - HOLD_INS and DEFAULT_INS default values.
- Sub-module prog_ram: DEPTH x INS_W, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Reset then HALT, ADDR=0 -> INS=21'h090114, CPU_CE=0, STATE=00, PROG_LEN=0, FETCH_OOB=0.
- LOAD_START; send 3 words A,B,C with LOAD_LAST on C, VALID toggled every other cycle -> LOAD_READY=1 throughout, INS=21'h01C0FF and CPU_CE=1 during load; after C: STATE=HALT, PROG_LEN=3.
- After load: RUN_EN=1, drive ADDR 0,1,2,3 -> INS=A,B,C,21'h090114; FETCH_OOB set on the ADDR=3 cycle; RUN_EN=0 -> HALT next cycle, CPU_CE=0.
- From HALT, STEP_REQ pulses ×2 spaced 3 cycles apart -> exactly 2 single-cycle CPU_CE pulses. LOAD_START coincident with STEP_REQ in HALT -> LOAD wins, FETCH_OOB cleared.
- DEPTH=4 build, stream 6 words with no LOAD_LAST -> 4 words accepted, PROG_LEN=4, LOAD_READY drops after the 4th, words 5-6 not written.
- RESET_N asserted mid-load after 2 words -> STATE=HALT immediately, PROG_LEN=0, INS=DEFAULT_INS for ADDR=0.
